// File: rtl/car_sprite_pkg.sv
// Shared types and default geometry for the player-car sprite fetcher.
package car_sprite_pkg;

    localparam int unsigned COLOR_W        = 5;
    localparam int unsigned SPRITE_W_DEF   = 32;
    localparam int unsigned SPRITE_H_DEF   = 64;
    localparam int unsigned V_TOTAL_DEF    = 525;
    localparam int unsigned TRANSP_IDX_DEF = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/car_line_buf.sv
// One-line sprite buffer: synchronous write port, combinational read port.
module car_line_buf
    import car_sprite_pkg::*;
#(
    parameter int unsigned DEPTH = SPRITE_W_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
)(
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [COLOR_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [COLOR_W-1:0] rdata_c_o
);

    // Contents are never reset; the fetcher's line_valid flag gates every read.
    logic [COLOR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/car_sprite_fetch.sv
// Fetches one car sprite row per scanline during h-blank and maps DrawX to a
// palette index plus car_on for the compositor.
module car_sprite_fetch
    import car_sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W   = SPRITE_W_DEF,
    parameter int unsigned SPRITE_H   = SPRITE_H_DEF,
    parameter int unsigned V_TOTAL    = V_TOTAL_DEF,
    parameter int unsigned TRANSP_IDX = TRANSP_IDX_DEF,
    parameter int unsigned ROM_AW     = $clog2(SPRITE_W * SPRITE_H)
)(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               line_start,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [9:0]         CarX,
    input  logic [9:0]         CarY,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] colorIdx,
    output logic               car_on,
    output logic               busy
);

    localparam int unsigned CW = $clog2(SPRITE_W);
    localparam int unsigned RW = ROM_AW - CW;
    localparam logic [COLOR_W-1:0] TRANSP = COLOR_W'(TRANSP_IDX);

    fetch_state_t       state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic               line_valid_q, line_valid_d;
    logic [9:0]         car_x_q, car_x_d;
    logic               busy_q, busy_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               car_on_q, car_on_d;

    logic [9:0]         next_y_c, row_c, dx_c;
    logic               hit_c, inside_c;
    logic               buf_we_c;
    logic [CW-1:0]      buf_waddr_c;
    logic [COLOR_W-1:0] buf_rd_c;

    // Row for the upcoming line; modular subtraction makes lines above the car miss.
    always_comb begin
        next_y_c = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
        row_c    = next_y_c - CarY;
        hit_c    = row_c < 10'(SPRITE_H);
    end

    // ROM data lags its address by one cycle, so writes trail col by one.
    always_comb begin
        buf_we_c    = 1'b0;
        buf_waddr_c = col_q - CW'(1);
        if (state_q == FETCH && col_q != '0) begin
            buf_we_c = 1'b1;
        end
        if (state_q == LAST) begin
            buf_we_c    = 1'b1;
            buf_waddr_c = CW'(SPRITE_W - 1);
        end
    end

    car_line_buf #(
        .DEPTH (SPRITE_W)
    ) u_buf (
        .clk_i     (Clk),
        .we_i      (buf_we_c),
        .waddr_i   (buf_waddr_c),
        .wdata_i   (rom_data),
        .raddr_i   (dx_c[CW-1:0]),
        .rdata_c_o (buf_rd_c)
    );

    // Fetch FSM; a line_start in any state restarts with the new row.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        rom_addr_d   = rom_addr_q;
        line_valid_d = line_valid_q;
        car_x_d      = car_x_q;

        if (line_start) begin
            car_x_d      = CarX;
            line_valid_d = 1'b0;
            if (hit_c) begin
                state_d    = FETCH;
                col_d      = '0;
                row_d      = row_c[RW-1:0];
                rom_addr_d = {row_c[RW-1:0], CW'(0)};
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (col_q == CW'(SPRITE_W - 1)) begin
                        state_d = LAST;
                    end else begin
                        col_d      = col_q + CW'(1);
                        rom_addr_d = {row_q, col_d};
                    end
                end
                LAST: begin
                    line_valid_d = 1'b1;
                    state_d      = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // Display path: one-cycle registered lookup relative to the latched CarX.
    always_comb begin
        dx_c     = DrawX - car_x_q;
        inside_c = line_valid_q && (dx_c < 10'(SPRITE_W));
        color_d  = inside_c ? buf_rd_c : TRANSP;
        car_on_d = inside_c && (buf_rd_c != TRANSP);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            rom_addr_q   <= '0;
            line_valid_q <= 1'b0;
            car_x_q      <= '0;
            busy_q       <= 1'b0;
            color_q      <= TRANSP;
            car_on_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            rom_addr_q   <= rom_addr_d;
            line_valid_q <= line_valid_d;
            car_x_q      <= car_x_d;
            busy_q       <= busy_d;
            color_q      <= color_d;
            car_on_q     <= car_on_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;
    assign colorIdx = color_q;
    assign car_on   = car_on_q;

endmodule

// File: tb/tb_car_sprite_fetch.sv
// Directed, table-driven bench for car_sprite_fetch with a one-cycle ROM model.
module tb_car_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        line_start;
    logic [9:0]  DrawX, DrawY, CarX, CarY;
    logic [10:0] rom_addr;
    logic [4:0]  rom_data;
    logic [4:0]  colorIdx;
    logic        car_on;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [10:0] addr_log [64];
    logic        busy_log [64];
    logic        on_log   [64];

    typedef struct {
        logic [9:0]  drawy;
        logic [9:0]  cary;
        logic        hit;
        logic [10:0] addr0;
    } fvec_t;

    typedef struct {
        logic [9:0] x;
        logic [4:0] idx;
        logic       on;
    } dvec_t;

    fvec_t fv [9];
    dvec_t dv [8];

    car_sprite_fetch dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .line_start (line_start),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .CarX       (CarX),
        .CarY       (CarY),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .colorIdx   (colorIdx),
        .car_on     (car_on),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    // Synchronous sprite ROM: data is the low five address bits.
    always @(posedge Clk) rom_data <= rom_addr[4:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Pulse line_start now; optionally pulse again with new DrawY/CarY at abort_k.
    task automatic run_line(input int ncyc, input int abort_k,
                            input logic [9:0] ay, input logic [9:0] acy);
        line_start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge Clk);
            addr_log[k] = rom_addr;
            busy_log[k] = busy;
            on_log[k]   = car_on;
            line_start  = (k == abort_k);
            if (k == abort_k) begin
                DrawY = ay;
                CarY  = acy;
            end
        end
        line_start = 1'b0;
    endtask

    function automatic int busy_count(input int ncyc);
        int n = 0;
        for (int k = 1; k <= ncyc; k++) if (busy_log[k]) n++;
        return n;
    endfunction

    function automatic int on_count(input int from, input int to);
        int n = 0;
        for (int k = from; k <= to; k++) if (on_log[k]) n++;
        return n;
    endfunction

    function automatic int first_on(input int ncyc);
        for (int k = 1; k <= ncyc; k++) if (on_log[k]) return k;
        return 0;
    endfunction

    initial begin
        fv[0] = '{10'd104, 10'd100,  1'b1, 11'd160};
        fv[1] = '{10'd524, 10'd0,    1'b1, 11'd0};
        fv[2] = '{10'd150, 10'd200,  1'b0, 11'd0};
        fv[3] = '{10'd163, 10'd100,  1'b0, 11'd0};
        fv[4] = '{10'd162, 10'd100,  1'b1, 11'd2016};
        fv[5] = '{10'd99,  10'd100,  1'b1, 11'd0};
        fv[6] = '{10'd523, 10'd500,  1'b1, 11'd768};
        fv[7] = '{10'd10,  10'd1000, 1'b1, 11'd1120};
        fv[8] = '{10'd0,   10'd2,    1'b0, 11'd0};

        dv[0] = '{10'd200, 5'd0,  1'b0};
        dv[1] = '{10'd201, 5'd1,  1'b1};
        dv[2] = '{10'd215, 5'd15, 1'b1};
        dv[3] = '{10'd231, 5'd31, 1'b1};
        dv[4] = '{10'd232, 5'd0,  1'b0};
        dv[5] = '{10'd199, 5'd0,  1'b0};
        dv[6] = '{10'd0,   5'd0,  1'b0};
        dv[7] = '{10'd216, 5'd16, 1'b1};

        Reset_n    = 1'b0;
        line_start = 1'b0;
        DrawX      = 10'd0;
        DrawY      = 10'd104;
        CarX       = 10'd200;
        CarY       = 10'd100;

        // Reset values, and line_start ignored while held in reset
        @(negedge Clk);
        check("rst_colorIdx", 32'(colorIdx), 0);
        check("rst_car_on",   32'(car_on),   0);
        check("rst_busy",     32'(busy),     0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        for (int i = 0; i < 5; i++) begin
            line_start = 1'b1;
            @(negedge Clk);
            check("rst_hold_busy", 32'(busy), 0);
        end
        line_start = 1'b0;
        Reset_n    = 1'b1;
        @(negedge Clk);
        check("post_rst_busy", 32'(busy), 0);

        // Next-line row computation: hits, misses, frame wrap, modular rows
        for (int i = 0; i < 9; i++) begin
            DrawY = fv[i].drawy;
            CarY  = fv[i].cary;
            run_line(40, 0, 10'd0, 10'd0);
            check($sformatf("vec%0d_busy_first", i), 32'(busy_log[1]), 32'(fv[i].hit));
            check($sformatf("vec%0d_busy_len", i), 32'(busy_count(40)), fv[i].hit ? 33 : 0);
            if (fv[i].hit) begin
                check($sformatf("vec%0d_addr_first", i), 32'(addr_log[1]), 32'(fv[i].addr0));
                check($sformatf("vec%0d_addr_last", i), 32'(addr_log[32]), 32'(fv[i].addr0) + 31);
            end
        end

        // Full hit fetch of row 5 with every address checked
        DrawY = 10'd104;
        CarY  = 10'd100;
        CarX  = 10'd200;
        run_line(40, 0, 10'd0, 10'd0);
        for (int k = 1; k <= 32; k++) begin
            check($sformatf("fetch_addr_col%0d", k - 1), 32'(addr_log[k]), 32'(160 + k - 1));
        end
        check("fetch_busy_len",   32'(busy_count(40)), 33);
        check("fetch_busy_last",  32'(busy_log[33]), 1);
        check("fetch_busy_after", 32'(busy_log[34]), 0);

        // Display lookup against buf[c] = c at CarX = 200
        for (int i = 0; i < 8; i++) begin
            DrawX = dv[i].x;
            @(negedge Clk);
            check($sformatf("disp_idx_x%0d", dv[i].x), 32'(colorIdx), 32'(dv[i].idx));
            check($sformatf("disp_on_x%0d", dv[i].x), 32'(car_on), 32'(dv[i].on));
        end

        // Missed line clears the previous line's valid data
        DrawY = 10'd150;
        CarY  = 10'd200;
        run_line(3, 0, 10'd0, 10'd0);
        check("miss_busy", 32'(busy_count(3)), 0);
        begin
            int n = 0;
            for (int x = 190; x <= 240; x++) begin
                DrawX = 10'(x);
                @(negedge Clk);
                if (car_on) n++;
            end
            check("miss_line_car_on", 32'(n), 0);
        end

        // Abort mid-fetch into a new hit row (row 11)
        DrawX = 10'd205;
        DrawY = 10'd104;
        CarY  = 10'd100;
        run_line(50, 10, 10'd110, 10'd100);
        check("abort_addr_before", 32'(addr_log[10]), 169);
        check("abort_addr_restart", 32'(addr_log[11]), 352);
        check("abort_addr_last", 32'(addr_log[42]), 383);
        check("abort_busy_len", 32'(busy_count(50)), 43);
        check("abort_first_on", 32'(first_on(50)), 45);

        // Abort mid-fetch into a missing row
        DrawY = 10'd104;
        CarY  = 10'd100;
        run_line(40, 10, 10'd150, 10'd200);
        check("abort_miss_busy_len", 32'(busy_count(40)), 10);
        check("abort_miss_car_on", 32'(on_count(2, 40)), 0);

        // Asynchronous reset at fetch cycle 15
        DrawY = 10'd104;
        CarY  = 10'd100;
        run_line(15, 0, 10'd0, 10'd0);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_busy",     32'(busy),     0);
        check("arst_rom_addr", 32'(rom_addr), 0);
        check("arst_car_on",   32'(car_on),   0);
        check("arst_colorIdx", 32'(colorIdx), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        begin
            int n = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge Clk);
                if (busy) n++;
            end
            check("arst_no_fetch", 32'(n), 0);
        end
        run_line(5, 0, 10'd0, 10'd0);
        check("arst_refetch_busy", 32'(busy_log[1]), 1);
        check("arst_refetch_addr", 32'(addr_log[1]), 160);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
